// File: rtl/alu_issue_stage.sv
// Execute-issue stage ahead of the 32-bit ALU: decodes MIPS opcode/funct into ALU controls,
// picks the B operand, and issues through a valid/ready register with a one-entry skid buffer.
module alu_issue_stage #(
    parameter int          DATA_W     = 32,
    parameter logic [2:0]  ILLEGAL_OP = 3'b010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_op,
    output logic [4:0]        out_dst,
    output logic              out_wr_en,
    output logic              out_is_beq,
    output logic              out_illegal
);
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic [4:0]        dst;
        logic              wr_en;
        logic              is_beq;
        logic              illegal;
    } entry_t;

    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                           OP_SUB = 3'b110, OP_SLT = 3'b111;

    entry_t dec, main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   accept, drain;

    logic [5:0]        opcode, funct;
    logic [4:0]        rt_f, rd_f;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sx, imm_zx;

    // The rs field is implied by in_rs_data; the register file already read it.
    logic unused_rs;
    assign unused_rs = ^in_instr[25:21];

    assign opcode = in_instr[31:26];
    assign rt_f   = in_instr[20:16];
    assign rd_f   = in_instr[15:11];
    assign funct  = in_instr[5:0];
    assign imm    = in_instr[15:0];
    assign imm_sx = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zx = {{(DATA_W-16){1'b0}}, imm};

    always_comb begin
        dec         = '0;
        dec.a       = in_rs_data;
        dec.b       = in_rt_data;
        dec.op      = ILLEGAL_OP;
        dec.illegal = 1'b1;
        case (opcode)
            6'h00: begin
                dec.illegal = 1'b0;
                dec.dst     = rd_f;
                dec.wr_en   = 1'b1;
                case (funct)
                    6'h20:   dec.op = OP_ADD;
                    6'h22:   dec.op = OP_SUB;
                    6'h24:   dec.op = OP_AND;
                    6'h25:   dec.op = OP_OR;
                    6'h2A:   dec.op = OP_SLT;
                    default: begin
                        dec.illegal = 1'b1;
                        dec.dst     = '0;
                        dec.wr_en   = 1'b0;
                    end
                endcase
            end
            6'h08: begin dec.op = OP_ADD; dec.b = imm_sx; dec.dst = rt_f; dec.wr_en = 1'b1; dec.illegal = 1'b0; end
            6'h0A: begin dec.op = OP_SLT; dec.b = imm_sx; dec.dst = rt_f; dec.wr_en = 1'b1; dec.illegal = 1'b0; end
            6'h0C: begin dec.op = OP_AND; dec.b = imm_zx; dec.dst = rt_f; dec.wr_en = 1'b1; dec.illegal = 1'b0; end
            6'h0D: begin dec.op = OP_OR;  dec.b = imm_zx; dec.dst = rt_f; dec.wr_en = 1'b1; dec.illegal = 1'b0; end
            6'h23: begin dec.op = OP_ADD; dec.b = imm_sx; dec.dst = rt_f; dec.wr_en = 1'b1; dec.illegal = 1'b0; end
            6'h2B: begin dec.op = OP_ADD; dec.b = imm_sx; dec.dst = rt_f; dec.illegal = 1'b0; end
            6'h04: begin dec.op = OP_SUB; dec.is_beq = 1'b1; dec.illegal = 1'b0; end
            default: ;
        endcase
        // $zero is never a write target.
        if (dec.dst == 5'd0)
            dec.wr_en = 1'b0;
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign drain    = ~main_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            // in_ready is low whenever skid is full, so skid refill and accept never collide.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_op      = main_q.op;
    assign out_dst     = main_q.dst;
    assign out_wr_en   = main_q.wr_en;
    assign out_is_beq  = main_q.is_beq;
    assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps then random traffic, checked against a
// two-deep FIFO model fed by a mnemonic-level decode of the MIPS subset.
module tb_alu_issue_stage;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_rs_data = '0, in_rt_data = '0;
    logic        in_ready, out_valid, out_wr_en, out_is_beq, out_illegal;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op;
    logic [4:0]  out_dst;

    alu_issue_stage #(.DATA_W(32), .ILLEGAL_OP(3'b010)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_dst(out_dst),
        .out_wr_en(out_wr_en), .out_is_beq(out_is_beq), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [4:0]  dst;
        logic        wr, beq, ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        int unsigned opc, fn, imm;
        logic [31:0] sx;
        opc   = int'(ins >> 26);
        fn    = int'(ins) & 32'h3F;
        imm   = int'(ins) & 32'hFFFF;
        sx    = (imm >= 32'h8000) ? (imm - 32'h10000) : imm;
        e.a   = rs; e.b = rt; e.op = 3'b010; e.dst = 5'd0;
        e.wr  = 1'b0; e.beq = 1'b0; e.ill = 1'b1;
        if (opc == 0) begin
            e.ill = 1'b0;
            if      (fn == 32'h20) e.op = 3'b010;
            else if (fn == 32'h22) e.op = 3'b110;
            else if (fn == 32'h24) e.op = 3'b000;
            else if (fn == 32'h25) e.op = 3'b001;
            else if (fn == 32'h2A) e.op = 3'b111;
            else e.ill = 1'b1;
            if (!e.ill) begin e.dst = 5'((ins >> 11) & 32'h1F); e.wr = 1'b1; end
        end else if (opc == 32'h04) begin
            e.op = 3'b110; e.beq = 1'b1; e.ill = 1'b0;
        end else if (opc == 32'h08 || opc == 32'h0A || opc == 32'h0C || opc == 32'h0D ||
                     opc == 32'h23 || opc == 32'h2B) begin
            e.ill = 1'b0;
            e.dst = 5'((ins >> 16) & 32'h1F);
            e.wr  = (opc != 32'h2B);
            case (opc)
                32'h0A:  begin e.op = 3'b111; e.b = sx;  end
                32'h0C:  begin e.op = 3'b000; e.b = imm; end
                32'h0D:  begin e.op = 3'b001; e.b = imm; end
                default: begin e.op = 3'b010; e.b = sx;  end
            endcase
        end
        if (e.dst == 5'd0) e.wr = 1'b0;
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_a", out_a, q[0].a);
            chk("out_b", out_b, q[0].b);
            chk("out_op", 32'(out_op), 32'(q[0].op));
            chk("out_dst", 32'(out_dst), 32'(q[0].dst));
            chk("out_wr_en", 32'(out_wr_en), 32'(q[0].wr));
            chk("out_is_beq", 32'(out_is_beq), 32'(q[0].beq));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end
    endtask

    // Called at a falling edge: check, drive, let one rising edge pass, update the model.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic ordy, input logic fl);
        logic acc;
        check_outputs();
        in_valid = iv; in_instr = ins; in_rs_data = rs; in_rt_data = rt;
        out_ready = ordy; flush = fl;
        acc = iv && (q.size() < 2);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(ins, rs, rt));
        end
        @(negedge clk);
    endtask

    logic [5:0]  opcs [10];
    logic [5:0]  fns  [5];
    logic [31:0] ins;

    initial begin
        opcs = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};
        fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_op", 32'(out_op), 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3,$1,$2 streamed back to back
        cycle(1, 32'h00221820, 5, 7, 1, 0);
        cycle(1, 32'h00221820, 11, 13, 1, 0);
        cycle(1, 32'h2004FFFF, 1, 2, 1, 0);
        cycle(1, 32'h3404FFFF, 3, 4, 1, 0);
        cycle(1, 32'h10220003, 9, 9, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("beq_ifbeq_dir", out_a - out_b, 0);

        // stall: three offers with out_ready low, then drain
        cycle(1, 32'h00221820, 32'hA1, 32'hB1, 0, 0);
        cycle(1, 32'h00432022, 32'hA2, 32'hB2, 0, 0);
        chk("stall_in_ready", 32'(in_ready), 0);
        cycle(1, 32'h00642824, 32'hA3, 32'hB3, 0, 0);
        cycle(1, 32'h00642824, 32'hA3, 32'hB3, 0, 0);
        cycle(1, 32'h00642824, 32'hA3, 32'hB3, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // flush with both entries full and an instruction offered
        cycle(1, 32'h00221820, 1, 1, 0, 0);
        cycle(1, 32'h00221820, 2, 2, 0, 0);
        cycle(1, 32'h00221825, 3, 3, 0, 1);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        cycle(0, 0, 0, 0, 1, 0);

        // illegal opcode, write to $zero, illegal funct
        cycle(1, 32'hFC221820, 4, 5, 1, 0);
        cycle(1, 32'h00220020, 4, 5, 1, 0);
        cycle(1, 32'h0022183F, 4, 5, 1, 0);
        cycle(1, 32'h8C25FFF0, 32'h100, 0, 1, 0);
        cycle(1, 32'hAC250010, 32'h100, 0, 1, 0);
        cycle(1, 32'h2825FFFE, 3, 0, 1, 0);
        cycle(1, 32'h3025ABCD, 3, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // asynchronous reset in the middle of a stall
        cycle(1, 32'h00221820, 6, 6, 0, 0);
        cycle(1, 32'h00221820, 7, 7, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_out_a", out_a, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            ins = {opcs[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
            if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0)
                ins[5:0] = fns[$urandom_range(0, 4)];
            cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage that sits directly upstream of the 32-bit ALU.
- Registers one decoded instruction per cycle and decodes opcode/funct into the 3-bit ALU operation (op2..op0).
- Selects the B operand (register or extended immediate) and presents Ai/Bi/op to the ALU.
- Uses a valid/ready handshake with a one-entry skid buffer so stalls from the consumer of the ALU result never drop instructions.

Parameters:
DATA_W, 32, operand width; must equal ALU width (32).
ILLEGAL_OP, 3'b010, ALU op driven for undecodable instructions.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held and incoming instructions (taken branch)
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_instr  input  32  MIPS instruction word
in_rs_data  input  DATA_W  register-file rs value
in_rt_data  input  DATA_W  register-file rt value
out_valid  output  1  ALU operands valid
out_ready  input  1  downstream accepts this cycle
out_a  output  DATA_W  ALU Ai
out_b  output  DATA_W  ALU Bi
out_op  output  3  ALU {op2,op1,op0}
out_dst  output  5  destination register
out_wr_en  output  1  result must be written back
out_is_beq  output  1  downstream uses ALU ifBeq for branch decision
out_illegal  output  1  unrecognised opcode/funct

Behaviour:
- Reset (rst_n low, asynchronous):
  - main_valid=0, skid_valid=0.
  - All out_* data = 0, out_valid=0, in_ready=1.
- in_ready = ~skid_valid. This is a registered state bit: there is no combinational path from out_ready to in_ready.
- Accept = in_valid & in_ready.
- Latency: accept at edge N puts out_valid=1 after edge N. Throughput is 1/cycle when out_ready stays high.
- Main register update rules:
  - Loads the accepted entry when main is empty or (out_valid & out_ready).
  - If the main entry is held (out_valid & ~out_ready) and accept=1, the new entry goes into skid.
  - When main drains and skid_valid=1, skid moves into main and skid_valid clears.
  - A simultaneous accept in that cycle is impossible because in_ready=0.
- Hold: while out_valid & ~out_ready, all out_* stay bit-stable.
- Flush has priority over everything. On an edge with flush=1:
  - main_valid and skid_valid clear.
  - Any accept in that cycle is discarded.
  - in_ready=1 the next cycle.
- ALU op encoding: AND 000, OR 001, ADD 010, SUB 110, SLT 111 (op2 = B-invert/carry-in).
- R-type decode (opcode 0x00), by funct:
  - 0x20 add → 010; 0x22 sub → 110; 0x24 and → 000; 0x25 or → 001; 0x2A slt → 111.
  - b = rt_data, dst = rd, wr_en = 1.
- I-type decode (dst = rt):
  - addi 0x08 → 010, sign-extend; slti 0x0A → 111, sign-extend.
  - andi 0x0C → 000, zero-extend; ori 0x0D → 001, zero-extend.
  - lw 0x23 → 010, sign-extend, wr_en = 1.
  - sw 0x2B → 010, sign-extend, wr_en = 0.
  - beq 0x04 → 110, b = rt_data, is_beq = 1, wr_en = 0, dst = 0.
- Always: a = rs_data.
- Any other opcode/funct: op = ILLEGAL_OP, illegal = 1, wr_en = 0, dst = 0, a/b = rs/rt data.
- Write suppression: dst == 0 forces wr_en = 0 ($zero is never written).
- Decode runs on the input side and is stored already decoded; the skid buffer stores decoded fields.
- Asserting rst_n low mid-stall drops both entries immediately; no partial state survives.

Test Plan:
1. Reset then stream `add $3,$1,$2` (0x00221820), rs=5, rt=7, out_ready=1 → next cycle out_valid=1, a=5, b=7, op=010, dst=3, wr_en=1; back-to-back issue at 1/cycle.
2. `addi $4,$0,-1` (0x2004FFFF) → b=0xFFFFFFFF, op=010. `ori $4,$0,0xFFFF` (0x3404FFFF) → b=0x0000FFFF, op=001.
3. `beq $1,$2,x` (0x10220003), rs=rt=9 → op=110, is_beq=1, wr_en=0; the ALU downstream then reports ifBeq=1.
4. Stall: out_ready=0 with 3 instructions offered on consecutive cycles → first held stable, second in skid, in_ready=0 on the third. Then out_ready=1 → outputs drain in order; nothing is lost or duplicated.
5. Flush with main and skid full while in_valid=1 → next cycle out_valid=0, in_ready=1; the offered instruction never appears.
6. Opcode 0x3F → illegal=1, op=ILLEGAL_OP, wr_en=0. `add $0,$1,$2` → wr_en=0. rst_n pulled low during stall → out_valid=0 asynchronously.
